// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: shared CP0 register numbers, field layouts and exception constants
package cp0_regfile_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEF_EXC_BASE_BEV  = 32'hBFC0_0200;
    localparam logic [31:0] DEF_EXC_BASE_NORM = 32'h8000_0000;
    localparam logic [31:0] DEF_GEN_OFFSET    = 32'h0000_0180;
    localparam logic [31:0] REFILL_OFFSET     = 32'h0000_0000;

    typedef struct packed {
        logic [8:0] rsv0;
        logic       bev;
        logic [5:0] rsv1;
        logic [7:0] im;
        logic [4:0] rsv2;
        logic       erl;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic [14:0] rsv0;
        logic [7:0]  ip;
        logic        rsv1;
        logic [4:0]  exc_code;
        logic [1:0]  rsv2;
    } cause_t;

    // Address-related exceptions are the only ones that record the faulting address
    function automatic logic sets_badvaddr(input logic [4:0] code);
        return code >= EXC_MOD && code <= EXC_ADES;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: half-rate Count, Compare register and sticky compare-match flag
module cp0_timer import cp0_regfile_pkg::*; (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_wen,
    input  logic        i_compare_wen,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_flag_next
);

    logic        r_toggle;
    logic        r_flag;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] w_count_next;

    assign w_count_next = i_count_wen ? i_wdata : r_count + {31'd0, r_toggle};
    assign o_flag_next  = !i_compare_wen && (r_flag || w_count_next == r_compare);
    assign o_count      = r_count;
    assign o_compare    = r_compare;

    // Count advances every other cycle; a Compare write clears the flag even on a match
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_toggle  <= 1'b0;
            r_flag    <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
        end else begin
            r_toggle  <= !i_count_wen && !r_toggle;
            r_flag    <= o_flag_next;
            r_count   <= w_count_next;
            if (i_compare_wen) r_compare <= i_wdata;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 architectural state, exception/eret commit and redirect generation
module cp0_regfile import cp0_regfile_pkg::*; #(
    parameter logic [31:0] EXC_BASE_BEV  = DEF_EXC_BASE_BEV,
    parameter logic [31:0] EXC_BASE_NORM = DEF_EXC_BASE_NORM,
    parameter logic [31:0] GEN_OFFSET    = DEF_GEN_OFFSET
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_valid,
    input  logic        exc_refill,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_badvaddr,
    input  logic        is_eret,
    input  logic [5:0]  ext_int,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    output logic [31:0] cp0_status,
    output logic [7:0]  interrupt_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    status_t     r_status;
    cause_t      r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_vec_base;
    logic [31:0] w_vec_off;
    logic        w_timer_flag_next;
    logic        w_do_wr;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

    // mtc0 only lands when neither an exception nor an eret commits this cycle
    assign w_do_wr     = wen && !exc_valid && !is_eret;
    assign w_wr_status = w_do_wr && waddr == CP0_STATUS;
    assign w_wr_cause  = w_do_wr && waddr == CP0_CAUSE;
    assign w_wr_epc    = w_do_wr && waddr == CP0_EPC;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_wen  (w_do_wr && waddr == CP0_COUNT),
        .i_compare_wen(w_do_wr && waddr == CP0_COMPARE),
        .i_wdata      (wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_flag_next  (w_timer_flag_next)
    );

    // Vector selection uses the pre-update Status: refill entry only when not already in EXL
    assign w_vec_base     = r_status.bev ? EXC_BASE_BEV : EXC_BASE_NORM;
    assign w_vec_off      = (exc_refill && !r_status.exl) ? REFILL_OFFSET : GEN_OFFSET;
    assign redirect_valid = exc_valid || is_eret;
    assign redirect_pc    = exc_valid ? w_vec_base + w_vec_off : r_epc;
    assign cp0_status     = r_status;
    assign interrupt_info = r_cause.ip & r_status.im;

    // mfc0 read mux straight from current register contents
    always_comb begin
        rdata = raddr == CP0_BADVADDR ? r_badvaddr :
                raddr == CP0_COUNT    ? w_count :
                raddr == CP0_COMPARE  ? w_compare :
                raddr == CP0_STATUS   ? r_status :
                raddr == CP0_CAUSE    ? r_cause :
                raddr == CP0_EPC      ? r_epc : 32'd0;
    end

    // Status: exception sets EXL, eret drops ERL first else EXL, mtc0 writes masked fields
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_status <= status_t'(STATUS_RESET);
        else if (exc_valid) r_status.exl <= 1'b1;
        else if (is_eret) begin
            if (r_status.erl) r_status.erl <= 1'b0;
            else r_status.exl <= 1'b0;
        end else if (w_wr_status)
            r_status <= status_t'((r_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK));
    end

    // Cause: IP[7:2] tracks interrupt lines each cycle, timer shares IP7 with ext_int[5]
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_cause <= '0;
        else begin
            r_cause.ip[7:2] <= {ext_int[5] | w_timer_flag_next, ext_int[4:0]};
            if (exc_valid) begin
                r_cause.exc_code <= exc_code;
                if (!r_status.exl) r_cause.bd <= exc_in_delay_slot;
            end else if (w_wr_cause) r_cause.ip[1:0] <= wdata[9:8];
        end
    end

    // EPC: nested exceptions keep the original return point
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_epc <= '0;
        else if (exc_valid) begin
            if (!r_status.exl) r_epc <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
        end else if (w_wr_epc) r_epc <= wdata;
    end

    // BadVAddr: captured only for address-related exception codes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_badvaddr <= '0;
        else if (exc_valid && sets_badvaddr(exc_code)) r_badvaddr <= exc_badvaddr;
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed plan checks plus randomized run against a field-level CP0 model
module tb_cp0_regfile;

    logic        clk;
    logic        resetn;
    logic        exc_valid;
    logic        exc_refill;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        is_eret;
    logic [5:0]  ext_int;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] cp0_status;
    logic [7:0]  interrupt_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_regfile dut (
        .clk              (clk),
        .resetn           (resetn),
        .exc_valid        (exc_valid),
        .exc_refill       (exc_refill),
        .exc_pc           (exc_pc),
        .exc_in_delay_slot(exc_in_delay_slot),
        .exc_code         (exc_code),
        .exc_badvaddr     (exc_badvaddr),
        .is_eret          (is_eret),
        .ext_int          (ext_int),
        .wen              (wen),
        .waddr            (waddr),
        .wdata            (wdata),
        .raddr            (raddr),
        .rdata            (rdata),
        .cp0_status       (cp0_status),
        .interrupt_info   (interrupt_info),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural fields kept separately; Count is half of a free-running tick count
    logic        m_bev, m_erl, m_exl, m_ie, m_bd, m_flag;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_compare;
    logic [32:0] m_half;
    logic        m_wr, m_cmp_wr, m_nflag;
    logic [32:0] m_nhalf;
    logic [31:0] m_status_v, m_cause_v, m_redir;

    assign m_wr       = wen && !exc_valid && !is_eret;
    assign m_cmp_wr   = m_wr && waddr == 5'd11;
    assign m_nhalf    = (m_wr && waddr == 5'd9) ? {wdata, 1'b0} : m_half + 33'd1;
    assign m_nflag    = m_cmp_wr ? 1'b0 : (m_flag || m_nhalf[32:1] == m_compare);
    assign m_status_v = {9'd0, m_bev, 6'd0, m_im, 5'd0, m_erl, m_exl, m_ie};
    assign m_cause_v  = {m_bd, 15'd0, m_ip, 1'b0, m_code, 2'b00};
    assign m_redir    = exc_valid ? ((m_bev ? 32'hBFC0_0200 : 32'h8000_0000) +
                                     ((exc_refill && !m_exl) ? 32'd0 : 32'h180)) : m_epc;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_bev <= 1'b1; m_erl <= 1'b0; m_exl <= 1'b0; m_ie <= 1'b0; m_bd <= 1'b0;
            m_im <= '0; m_ip <= '0; m_code <= '0; m_epc <= '0; m_badv <= '0;
            m_compare <= '0; m_half <= '0; m_flag <= 1'b0;
        end else begin
            m_half <= m_nhalf;
            m_flag <= m_nflag;
            m_ip[7:2] <= {ext_int[5] | m_nflag, ext_int[4:0]};
            if (exc_valid) begin
                m_code <= exc_code;
                if (!m_exl) begin
                    m_epc <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    m_bd  <= exc_in_delay_slot;
                end
                m_exl <= 1'b1;
                if (exc_code >= 5'd1 && exc_code <= 5'd5) m_badv <= exc_badvaddr;
            end else if (is_eret) begin
                if (m_erl) m_erl <= 1'b0;
                else m_exl <= 1'b0;
            end else if (wen) begin
                case (waddr)
                    5'd11: m_compare <= wdata;
                    5'd12: begin
                        m_bev <= wdata[22]; m_im <= wdata[15:8];
                        m_erl <= wdata[2]; m_exl <= wdata[1]; m_ie <= wdata[0];
                    end
                    5'd13: m_ip[1:0] <= wdata[9:8];
                    5'd14: m_epc <= wdata;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_half[32:1];
            5'd11: return m_compare;
            5'd12: return m_status_v;
            5'd13: return m_cause_v;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        exc_valid = 0; exc_refill = 0; exc_pc = '0; exc_in_delay_slot = 0; exc_code = '0;
        exc_badvaddr = '0; is_eret = 0; ext_int = '0; wen = 0; waddr = '0; wdata = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] mask, input string tag, input logic [31:0] exp);
        raddr = a;
        #1 chk(tag, rdata & mask, exp);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        wen = 1; waddr = a; wdata = d;
        @(negedge clk);
        idle();
    endtask

    task automatic exc(input logic refill, input logic [31:0] pc, input logic ds,
                       input logic [4:0] code, input logic [31:0] bva);
        exc_valid = 1; exc_refill = refill; exc_pc = pc; exc_in_delay_slot = ds;
        exc_code = code; exc_badvaddr = bva;
    endtask

    task automatic check_all();
        #1;
        chk("status", cp0_status, m_status_v);
        chk("int_info", 32'(interrupt_info), 32'(m_ip & m_im));
        chk("redir_valid", 32'(redirect_valid), 32'(exc_valid | is_eret));
        if (exc_valid || is_eret) chk("redir_pc", redirect_pc, m_redir);
        chk("rdata", rdata, m_rd(raddr));
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        int k = $urandom_range(0, 8);
        return k == 8 ? 5'($urandom) : addrs[k];
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return m_half[32:1] + 32'($urandom_range(0, 5));
            2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        resetn = 0;
        raddr = 5'd12;
        idle();
        repeat (2) @(negedge clk);
        resetn = 1;
        rd(5'd12, 32'hFFFF_FFFF, "rst_status", 32'h0040_0000);
        chk("rst_int_info", 32'(interrupt_info), 32'd0);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        @(negedge clk);

        exc(1'b0, 32'h8000_1004, 1'b1, 5'd4, 32'h1235);
        #1 chk("exc1_redir", redirect_pc, 32'hBFC0_0380);
        chk("exc1_valid", 32'(redirect_valid), 32'd1);
        @(negedge clk);
        idle();
        rd(5'd14, 32'hFFFF_FFFF, "exc1_epc", 32'h8000_1000);
        rd(5'd13, 32'h8000_007C, "exc1_cause", 32'h8000_0010);
        rd(5'd8, 32'hFFFF_FFFF, "exc1_badv", 32'h1235);
        rd(5'd12, 32'hFFFF_FFFF, "exc1_status", 32'h0040_0002);

        exc(1'b0, 32'h8000_2000, 1'b0, 5'd8, 32'hDEAD);
        #1 chk("exc2_redir", redirect_pc, 32'hBFC0_0380);
        @(negedge clk);
        idle();
        rd(5'd14, 32'hFFFF_FFFF, "exc2_epc", 32'h8000_1000);
        rd(5'd13, 32'h8000_007C, "exc2_cause", 32'h8000_0020);
        rd(5'd8, 32'hFFFF_FFFF, "exc2_badv", 32'h1235);

        mtc0(5'd12, 32'h0);
        exc(1'b1, 32'h0040_0000, 1'b0, 5'd2, 32'h10);
        #1 chk("refill_exl0", redirect_pc, 32'h8000_0000);
        @(negedge clk);
        exc(1'b1, 32'h0040_0000, 1'b0, 5'd2, 32'h10);
        #1 chk("refill_exl1", redirect_pc, 32'h8000_0180);
        @(negedge clk);
        idle();

        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd4);
        mtc0(5'd9, 32'd0);
        repeat (7) @(negedge clk);
        raddr = 5'd9;
        #1 chk("timer_pre_count", rdata, 32'd3);
        chk("timer_pre_int", 32'(interrupt_info), 32'd0);
        @(negedge clk);
        #1 chk("timer_count", rdata, 32'd4);
        chk("timer_int", 32'(interrupt_info), 32'h80);
        @(negedge clk);
        mtc0(5'd11, 32'd100);
        #1 chk("timer_clear", 32'(interrupt_info), 32'd0);
        @(negedge clk);

        exc(1'b0, 32'h8000_3000, 1'b0, 5'd10, 32'h0);
        is_eret = 1; wen = 1; waddr = 5'd14; wdata = 32'h1234_5678;
        #1 chk("prio_redir", redirect_pc, 32'h8000_0180);
        @(negedge clk);
        idle();
        rd(5'd14, 32'hFFFF_FFFF, "prio_epc", 32'h8000_3000);
        rd(5'd12, 32'h0000_0002, "prio_exl", 32'h0000_0002);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 resetn = 0;
                raddr = 5'd14;
                #1 chk("mid_rst_status", cp0_status, 32'h0040_0000);
                chk("mid_rst_int", 32'(interrupt_info), 32'd0);
                chk("mid_rst_epc", rdata, 32'd0);
                @(negedge clk);
                resetn = 1;
            end
            exc_valid = $urandom_range(0, 7) == 0;
            exc_refill = $urandom_range(0, 1) == 1;
            exc_pc = $urandom;
            exc_in_delay_slot = $urandom_range(0, 1) == 1;
            exc_code = 5'($urandom_range(0, 15));
            exc_badvaddr = $urandom;
            is_eret = $urandom_range(0, 7) == 0;
            ext_int = $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'd0;
            wen = $urandom_range(0, 2) == 0;
            waddr = pick_addr();
            wdata = pick_data();
            raddr = pick_addr();
            check_all();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
